fma16_issue: RTL and testbench
==============================

# fma16_issue

Sequential issue/retire stage wrapped around the combinational `fma16` datapath. It accepts opcode-encoded half-precision requests over a valid/ready handshake and decodes them into `fma16` controls. Operands are registered onto the `fma16` inputs, and each result is captured with its flags into a small output queue. Exception flags from every retired operation are accumulated into a sticky `fflags` register.

## Interface
- `OUT_DEPTH`, default 2: output queue entries (≥1).
- `clk  in  1  clock`
- `reset  in  1  reset, synchronous, active-low`
- `in_valid  in  1  request valid`
- `in_ready  out  1  request accepted when in_valid & in_ready at posedge`
- `in_op  in  3  opcode (see Operation)`
- `in_rm  in  2  roundmode: 00 RZ, 01 RNE, 10 RDN, 11 RUP`
- `in_x, in_y, in_z  in  16  binary16 operands`
- `fma_x, fma_y, fma_z  out  16  operands to fma16`
- `fma_mul, fma_add, fma_negp, fma_negz  out  1  controls to fma16`
- `fma_roundmode  out  2  roundmode to fma16`
- `fma_result  in  16  fma16 result`
- `fma_flags  in  4  fma16 flags {invalid, overflow, underflow, inexact}`
- `out_valid  out  1  head of output queue valid`
- `out_ready  in  1  consumer accepts head`
- `out_result  out  16  head result`
- `out_flags  out  4  head flags`
- `fflags  out  4  sticky OR of retired flags`
- `fflags_clr  in  1  clear sticky flags`

## Operation
- Opcode decode to {mul, add, negp, negz}:
  - 000 FMADD x·y+z: 1100
  - 001 FMSUB x·y−z: 1101
  - 010 FNMSUB −x·y+z: 1110
  - 011 FNMADD −x·y−z: 1111
  - 100 FMUL x·y: 1000
  - 101 FADD x+z: 0100
  - 110 FSUB x−z: 0101
  - 111 illegal
- Stage 1 (S1) register: valid bit, illegal bit, operands, controls, and rm. It drives `fma_*` directly.
- Illegal op handling:
  - Accepted normally; `fma_*` controls are driven 0.
  - Queue captures result 16'h7E00 and flags 4'b1000 instead of `fma16` output.
- S1 drains into the queue at a posedge when S1 is valid and the queue can accept. "Can accept" means count < OUT_DEPTH, or a pop happens the same cycle.
- `in_ready` = reset deasserted & (~S1 valid | S1 drains this cycle). This is a combinational path from `out_ready` to `in_ready`.
- When S1 is empty, `fma_*` holds its last value.
- Queue is FIFO order; `out_*` shows the head; pop on `out_valid & out_ready`.
- Sticky flags:
  - Next `fflags` = (fflags_clr ? 0 : fflags) | (pop ? out_flags : 0).
  - Clear and pop in the same cycle leaves only the popped flags.
- Simultaneous push and pop on a full queue is allowed; count is unchanged.

## Timing
- Reset (reset=0 at posedge) clears:
  - S1 valid, queue count, `fflags` → 0.
  - `fma_*` → 0; `out_result`, `out_flags` → 0.
- While reset=0: `in_ready`=0 and `out_valid`=0.
- Reset mid-operation discards S1 and all queued entries; no flags are accumulated from them.
- Latency: request accepted at edge N → `fma_*` valid after N → result captured at N+1 → `out_valid` high after N+1 (2 cycles).
- Throughput is 1 op/cycle when `out_ready`=1.
- With `out_ready`=0, exactly 1+OUT_DEPTH requests are accepted before `in_ready` falls.
- `out_result`/`out_flags` are stable while `out_valid` & ~`out_ready`.

## Structure
- `fma16_pkg` holds:
  - opcode enum (`FMADD`..`FSUB`, `ILLEGAL`)
  - roundmode enum
  - flag bit indices
  - `QNAN16 = 16'h7E00`
  - `FLAG_INVALID = 4'b1000`
- Sub-module `fma16_outq`: a parameterised {result, flags} FIFO with count, full/empty, and push/pop. It is instantiated once.
- `fma16` is instantiated by the parent, not inside this block.

## Test plan
- FMADD, rm=01, x=3C00 y=4000 z=3C00 → `out_result`=4200, `out_flags`=0000, `out_valid` 2 cycles after accept.
- FMUL 4000·4200 then FSUB x=4200 z=3C00, back-to-back with `out_ready`=1 → 4600 then 4000 on consecutive cycles, in order.
- Op 111 → 7E00 / 1000; `fflags`=1000 after pop.
- FMADD x=7BFF y=7BFF z=0000, rm=01 → 7C00 / 0101; `fflags`=0101. Then pop an exact op with `fflags_clr`=1 the same cycle → `fflags`=0000.
- `out_ready`=0, OUT_DEPTH=2, stream 5 requests → 3 accepted, `in_ready`=0 with 2 held. Raise `out_ready` → all 5 retire in order, no loss or duplication.
- Reset pulsed with 2 entries queued → next cycle `out_valid`=0, `fflags`=0000, `in_ready`=1.

Source files
------------

// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 issue/retire stage.
package fma16_pkg;

   typedef enum logic [2:0] {
      FMADD   = 3'b000,
      FMSUB   = 3'b001,
      FNMSUB  = 3'b010,
      FNMADD  = 3'b011,
      FMUL    = 3'b100,
      FADD    = 3'b101,
      FSUB    = 3'b110,
      ILLEGAL = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      RM_RZ  = 2'b00,
      RM_RNE = 2'b01,
      RM_RDN = 2'b10,
      RM_RUP = 2'b11
   } roundmode_e;

   localparam int unsigned FLAG_NV = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   localparam logic [15:0] QNAN16       = 16'h7E00;
   localparam logic [3:0]  FLAG_INVALID = 4'(1) << FLAG_NV;

   typedef struct packed {
      logic mul;
      logic add;
      logic negp;
      logic negz;
   } fma_ctrl_t;

   typedef struct packed {
      logic [15:0] result;
      logic [3:0]  flags;
   } outq_entry_t;

   // Illegal ops decode to all-zero controls so fma16 sees a benign request.
   function automatic fma_ctrl_t decode_op(input opcode_e op);
      fma_ctrl_t c;
      c = '0;
      unique case (op)
         FMADD:   c = '{mul: 1'b1, add: 1'b1, negp: 1'b0, negz: 1'b0};
         FMSUB:   c = '{mul: 1'b1, add: 1'b1, negp: 1'b0, negz: 1'b1};
         FNMSUB:  c = '{mul: 1'b1, add: 1'b1, negp: 1'b1, negz: 1'b0};
         FNMADD:  c = '{mul: 1'b1, add: 1'b1, negp: 1'b1, negz: 1'b1};
         FMUL:    c = '{mul: 1'b1, add: 1'b0, negp: 1'b0, negz: 1'b0};
         FADD:    c = '{mul: 1'b0, add: 1'b1, negp: 1'b0, negz: 1'b0};
         FSUB:    c = '{mul: 1'b0, add: 1'b1, negp: 1'b0, negz: 1'b1};
         ILLEGAL: c = '0;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fma16_issue_if.sv
// Request, fma16 datapath and retire signals of the fma16 issue stage.
interface fma16_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [1:0]  in_rm;
   logic [15:0] in_x, in_y, in_z;
   logic [15:0] fma_x, fma_y, fma_z;
   logic        fma_mul, fma_add, fma_negp, fma_negz;
   logic [1:0]  fma_roundmode;
   logic [15:0] fma_result;
   logic [3:0]  fma_flags;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_flags;
   logic [3:0]  fflags;
   logic        fflags_clr;

   modport slave (
      input  in_valid, in_op, in_rm, in_x, in_y, in_z, fma_result, fma_flags, out_ready,
             fflags_clr,
      output in_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz,
             fma_roundmode, out_valid, out_result, out_flags, fflags
   );

   modport master (
      output in_valid, in_op, in_rm, in_x, in_y, in_z, fma_result, fma_flags, out_ready,
             fflags_clr,
      input  in_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz,
             fma_roundmode, out_valid, out_result, out_flags, fflags
   );
endinterface

// File: rtl/fma16_outq.sv
// FIFO of retired {result, flags}; push and pop may coincide even when full.
module fma16_outq
   import fma16_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  outq_entry_t push_entry,
   input  logic        pop,
   output outq_entry_t head,
   output logic        full,
   output logic        empty
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   outq_entry_t     mem_q [Depth];
   logic [PtrW-1:0] wr_q, rd_q;
   logic [CntW-1:0] cnt_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= push_entry;
            wr_q        <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         if (push && !pop) cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   assign head  = mem_q[rd_q];
   assign full  = (cnt_q == CntW'(Depth));
   assign empty = (cnt_q == '0);
endmodule

// File: rtl/fma16_issue.sv
// Issue/retire stage around fma16: decode into S1, capture results in a queue, sticky flags.
module fma16_issue
   import fma16_pkg::*;
#(
   parameter int unsigned OUT_DEPTH = 2
) (
   input logic          clk,
   input logic          reset,
   fma16_issue_if.slave bus
);
   logic        s1_valid_q, s1_illegal_q;
   logic [15:0] fma_x_q, fma_y_q, fma_z_q;
   fma_ctrl_t   ctrl_q, in_ctrl;
   roundmode_e  rm_q;
   logic [3:0]  fflags_q, fflags_d;
   logic        in_illegal, accept, drain, pop, out_valid;
   logic        q_full, q_empty;
   outq_entry_t push_entry, head;

   always_comb begin
      in_illegal = (opcode_e'(bus.in_op) == ILLEGAL);
      in_ctrl    = decode_op(opcode_e'(bus.in_op));
      out_valid  = reset & ~q_empty;
      pop        = out_valid & bus.out_ready;
      // A pop frees a slot in the same cycle, so a full queue still takes S1.
      drain      = s1_valid_q & (~q_full | pop);
      accept     = bus.in_valid & reset & (~s1_valid_q | drain);
      push_entry = s1_illegal_q ? '{result: QNAN16, flags: FLAG_INVALID}
                                : '{result: bus.fma_result, flags: bus.fma_flags};
      fflags_d   = (bus.fflags_clr ? 4'b0000 : fflags_q) | (pop ? head.flags : 4'b0000);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q   <= 1'b0;
         s1_illegal_q <= 1'b0;
         fma_x_q      <= '0;
         fma_y_q      <= '0;
         fma_z_q      <= '0;
         ctrl_q       <= '0;
         rm_q         <= RM_RZ;
         fflags_q     <= '0;
      end else begin
         fflags_q <= fflags_d;
         if (accept) begin
            s1_valid_q   <= 1'b1;
            s1_illegal_q <= in_illegal;
            fma_x_q      <= bus.in_x;
            fma_y_q      <= bus.in_y;
            fma_z_q      <= bus.in_z;
            ctrl_q       <= in_ctrl;
            rm_q         <= roundmode_e'(bus.in_rm);
         end else if (drain) begin
            s1_valid_q <= 1'b0;
         end
      end
   end

   fma16_outq #(
      .Depth(OUT_DEPTH)
   ) u_outq (
      .clk       (clk),
      .reset     (reset),
      .push      (drain),
      .push_entry(push_entry),
      .pop       (pop),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign bus.in_ready      = reset & (~s1_valid_q | drain);
   assign bus.fma_x         = fma_x_q;
   assign bus.fma_y         = fma_y_q;
   assign bus.fma_z         = fma_z_q;
   assign bus.fma_mul       = ctrl_q.mul;
   assign bus.fma_add       = ctrl_q.add;
   assign bus.fma_negp      = ctrl_q.negp;
   assign bus.fma_negz      = ctrl_q.negz;
   assign bus.fma_roundmode = rm_q;
   assign bus.out_valid     = out_valid;
   assign bus.out_result    = head.result;
   assign bus.out_flags     = head.flags;
   assign bus.fflags        = fflags_q;
endmodule

// File: tb/tb_fma16_issue.sv
// Scoreboard bench for fma16_issue with a table-driven stand-in for the fma16 datapath.
module tb_fma16_issue;
   import fma16_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fma16_issue_if bus();

   fma16_issue #(
      .OUT_DEPTH(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_accepted = 0;
   logic [19:0] exp_q[$];
   logic [19:0] fake_out;

   // Known-answer stand-in for fma16; any unexpected control/operand mix yields DEAD/0110.
   function automatic logic [19:0] fake_fma(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z, input logic [3:0] c,
                                            input logic [1:0] rm);
      if (c == 4'b1100 && x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && rm == 2'b01)
         return {16'h4200, 4'b0000};
      if (c == 4'b1100 && x == 16'h7BFF && y == 16'h7BFF && z == 16'h0000 && rm == 2'b01)
         return {16'h7C00, 4'b0101};
      if (c == 4'b1000 && x == 16'h4000 && y == 16'h4200 && rm == 2'b01)
         return {16'h4600, 4'b0000};
      if (c == 4'b0101 && x == 16'h4200 && z == 16'h3C00 && rm == 2'b01)
         return {16'h4000, 4'b0000};
      if (c == 4'b0100 && x == 16'h3C00 && z == 16'h3C00 && (rm == 2'b01 || rm == 2'b10))
         return {16'h4000, 4'b0000};
      if (c == 4'b1101 && x == 16'h4000 && y == 16'h4000 && z == 16'h3C00 && rm == 2'b01)
         return {16'h4200, 4'b0000};
      if (c == 4'b1110 && x == 16'h4000 && y == 16'h4000 && z == 16'h3C00 && rm == 2'b01)
         return {16'hC200, 4'b0000};
      if (c == 4'b1111 && x == 16'h4000 && y == 16'h4000 && z == 16'h3C00 && rm == 2'b01)
         return {16'hC500, 4'b0000};
      return {16'hDEAD, 4'b0110};
   endfunction

   always_comb fake_out = fake_fma(bus.fma_x, bus.fma_y, bus.fma_z,
                                   {bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz},
                                   bus.fma_roundmode);
   assign bus.fma_result = fake_out[19:4];
   assign bus.fma_flags  = fake_out[3:0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every retired entry must match the oldest expectation.
   always @(negedge clk) begin
      logic [19:0] e;
      if (reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {12'h000, bus.out_result, bus.out_flags}, 32'hFFFFFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("out_result", {16'h0000, bus.out_result}, {16'h0000, e[19:4]});
            chk("out_flags", {28'h0, bus.out_flags}, {28'h0, e[3:0]});
         end
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input logic [2:0] op, input logic [1:0] rm, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] z, input logic [15:0] er,
                        input logic [3:0] ef);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rm    = rm;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_z     = z;
      @(negedge clk);
      while (!bus.in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
      end else begin
         exp_q.push_back({er, ef});
         n_accepted++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_op      = 3'b000;
      bus.in_rm      = 2'b00;
      bus.in_x       = 16'h0000;
      bus.in_y       = 16'h0000;
      bus.in_z       = 16'h0000;
      bus.out_ready  = 1'b0;
      bus.fflags_clr = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_fflags", {28'h0, bus.fflags}, 32'd0);
      chk("rst_fma_x", {16'h0, bus.fma_x}, 32'd0);
      chk("rst_fma_ctrl", {28'h0, bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz}, 32'd0);
      chk("rst_out_result", {16'h0, bus.out_result, bus.out_flags}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.out_ready = 1'b1;

      // FMADD latency: fma_* loaded one cycle after accept, out_valid the cycle after.
      issue(3'(FMADD), 2'b01, 16'h3C00, 16'h4000, 16'h3C00, 16'h4200, 4'b0000);
      @(negedge clk);
      chk("lat_out_valid_early", {31'b0, bus.out_valid}, 32'd0);
      chk("lat_fma_x", {16'h0, bus.fma_x}, 32'h3C00);
      chk("lat_fma_ctrl", {28'h0, bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz},
          32'b1100);
      chk("lat_fma_rm", {30'h0, bus.fma_roundmode}, 32'd1);
      @(negedge clk);
      chk("lat_out_valid", {31'b0, bus.out_valid}, 32'd1);
      wait_idle();

      // Back-to-back FMUL then FSUB retire on consecutive cycles.
      issue(3'(FMUL), 2'b01, 16'h4000, 16'h4200, 16'h0000, 16'h4600, 4'b0000);
      issue(3'(FSUB), 2'b01, 16'h4200, 16'h0000, 16'h3C00, 16'h4000, 4'b0000);
      @(negedge clk);
      chk("b2b_first", {15'h0, bus.out_valid, bus.out_result}, {16'h0001, 16'h4600});
      @(negedge clk);
      chk("b2b_second", {15'h0, bus.out_valid, bus.out_result}, {16'h0001, 16'h4000});
      wait_idle();

      // Illegal op: controls zeroed, NaN/invalid retired, sticky invalid.
      issue(3'(ILLEGAL), 2'b01, 16'h3C00, 16'h4000, 16'h3C00, QNAN16, FLAG_INVALID);
      @(negedge clk);
      chk("ill_fma_ctrl", {28'h0, bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz}, 32'd0);
      wait_idle();
      @(negedge clk);
      chk("ill_fflags", {28'h0, bus.fflags}, 32'b1000);
      @(posedge clk);
      #1;
      bus.fflags_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.fflags_clr = 1'b0;
      @(negedge clk);
      chk("clr_fflags", {28'h0, bus.fflags}, 32'd0);

      // Overflow sets OF|NX; then a clear coinciding with an exact pop leaves zero.
      @(posedge clk);
      #1;
      issue(3'(FMADD), 2'b01, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 4'b0101);
      wait_idle();
      @(negedge clk);
      chk("ovf_fflags", {28'h0, bus.fflags}, 32'b0101);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      issue(3'(FADD), 2'b10, 16'h3C00, 16'h0000, 16'h3C00, 16'h4000, 4'b0000);
      @(posedge clk);
      #1;
      bus.out_ready  = 1'b1;
      bus.fflags_clr = 1'b1;
      @(negedge clk);
      chk("clrpop_before", {28'h0, bus.fflags}, 32'b0101);
      @(posedge clk);
      #1;
      bus.fflags_clr = 1'b0;
      @(negedge clk);
      chk("clrpop_fflags", {28'h0, bus.fflags}, 32'd0);

      // Backpressure: with out_ready low exactly three of five requests get in.
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      n_accepted = 0;
      fork
         begin
            issue(3'(FMSUB), 2'b01, 16'h4000, 16'h4000, 16'h3C00, 16'h4200, 4'b0000);
            issue(3'(FNMSUB), 2'b01, 16'h4000, 16'h4000, 16'h3C00, 16'hC200, 4'b0000);
            issue(3'(FNMADD), 2'b01, 16'h4000, 16'h4000, 16'h3C00, 16'hC500, 4'b0000);
            issue(3'(FADD), 2'b01, 16'h3C00, 16'h0000, 16'h3C00, 16'h4000, 4'b0000);
            issue(3'(FMUL), 2'b01, 16'h4000, 16'h4200, 16'h0000, 16'h4600, 4'b0000);
         end
         begin
            repeat (8) @(negedge clk);
            chk("bp_accepted", n_accepted, 3);
            chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("bp_head", {15'h0, bus.out_valid, bus.out_result}, {16'h0001, 16'h4200});
            @(negedge clk);
            chk("bp_head_stable", {16'h0, bus.out_result}, 32'h4200);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("bp_total", n_accepted, 5);

      // Reset with two entries queued discards them and their flags.
      bus.out_ready = 1'b0;
      issue(3'(ILLEGAL), 2'b01, 16'h0000, 16'h0000, 16'h0000, QNAN16, FLAG_INVALID);
      issue(3'(ILLEGAL), 2'b01, 16'h0000, 16'h0000, 16'h0000, QNAN16, FLAG_INVALID);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.out_ready = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("mrst_fflags", {28'h0, bus.fflags}, 32'd0);
      chk("mrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("mrst_out_result", {16'h0, bus.out_result}, 32'd0);

      @(posedge clk);
      #1;
      issue(3'(FMADD), 2'b01, 16'h3C00, 16'h4000, 16'h3C00, 16'h4200, 4'b0000);
      wait_idle();
      @(negedge clk);
      chk("final_fflags", {28'h0, bus.fflags}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
